input_conditioner: RTL and testbench

//  Input-side front end for the board: synchronizes, debounces and edge-detects SW[9:0] and KEY[1:0].

---
 rtl/input_conditioner.sv | 120 ++++++++++++
 tb/tb_input_conditioner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: board input front end for SW and KEY pins.
// Each pin is passed through a 2-flop synchronizer and debounced per bit. The block
// produces clean levels plus 1-cycle change, press and release pulses. design_sel
// follows the debounced top switch.
// Optional build macro LONG_PRESS_EN adds per-key hold counters that drive key_long.
// Without this macro, key_long is tied to 0.
module input_conditioner #(
  parameter int N_SW            = 10,
  parameter int N_KEY           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_raw,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_SW-1:0]  sw_change,
  output logic [N_KEY-1:0] key_down,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic             design_sel,
  output logic [N_KEY-1:0] key_long
);

  localparam int N  = N_SW + N_KEY;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  sw_s1, sw_s2;
  logic [N_KEY-1:0] key_s1, key_s2;
  logic [N-1:0]     samp;
  logic [N-1:0]     stable;
  logic [N-1:0]     rise;
  logic [N-1:0]     fall;
  logic [CW-1:0]    cnt [N];

  // two-flop synchronizers; keys idle high (released) so reset matches a released key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
      key_s1 <= key_raw;
      key_s2 <= key_s1;
    end
  end

  // keys are inverted after the chain so every sample bit reads 1 = active
  assign samp = {~key_s2, sw_s2};

  // per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < N; i++) begin
        if (samp[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_TC) begin
          stable[i] <= samp[i];
          cnt[i]    <= '0;
          rise[i]   <= samp[i];
          fall[i]   <= ~samp[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sw_clean    = stable[N_SW-1:0];
  assign sw_change   = rise[N_SW-1:0] | fall[N_SW-1:0];
  assign key_down    = stable[N-1:N_SW];
  assign key_press   = rise[N-1:N_SW];
  assign key_release = fall[N-1:N_SW];
  assign design_sel  = stable[N_SW-1];

`ifdef LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LP_TC  = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LP_MAX = LW'(LONG_CYCLES);

  logic [LW-1:0]    hold [N_KEY];
  logic [N_KEY-1:0] long_q;

  // hold counters saturate at LONG_CYCLES so the long pulse fires only once per press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= '0;
      for (int k = 0; k < N_KEY; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < N_KEY; k++) begin
        long_q[k] <= key_down[k] && (hold[k] == LP_TC);
        if (!key_down[k]) begin
          hold[k] <= '0;
        end else if (hold[k] != LP_MAX) begin
          hold[k] <= hold[k] + 1'b1;
        end
      end
    end
  end

  assign key_long = long_q;
`else
  logic unused_long_cycles;
  assign unused_long_cycles = (LONG_CYCLES > 0);
  assign key_long = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// With this timing, a raw edge shows up on the clean outputs 6 falling edges later.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sw_raw;
  logic [1:0] key_raw;
  logic [9:0] sw_clean;
  logic [9:0] sw_change;
  logic [1:0] key_down;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic       design_sel;
  logic [1:0] key_long;

  int n_tests = 0;
  int n_fail  = 0;
  int busy;
  int npulse;
  int at;

  always #5 clk = ~clk;

  input_conditioner #(
    .N_SW(10), .N_KEY(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .key_raw(key_raw),
    .sw_clean(sw_clean), .sw_change(sw_change), .key_down(key_down),
    .key_press(key_press), .key_release(key_release),
    .design_sel(design_sel), .key_long(key_long)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset with keys released and switches low
    rst_n   = 1'b0;
    sw_raw  = '0;
    key_raw = 2'b11;
    cyc(3);
    check("rst_sw_clean", 32'(sw_clean), 0);
    check("rst_key_down", 32'(key_down), 0);
    rst_n = 1'b1;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (|{sw_clean, sw_change, key_down, key_press, key_release, key_long, design_sel}) busy++;
    end
    check("t1_idle", 32'(busy), 0);

    // key 0 press and release
    key_raw[0] = 1'b0;
    cyc(5);
    check("t2_kd_early", 32'(key_down), 0);
    check("t2_kp_early", 32'(key_press), 0);
    cyc(1);
    check("t2_kd", 32'(key_down), 1);
    check("t2_kp", 32'(key_press), 1);
    cyc(1);
    check("t2_kp_1cyc", 32'(key_press), 0);
    check("t2_kd_hold", 32'(key_down), 1);
    cyc(5);
    key_raw[0] = 1'b1;
    cyc(5);
    check("t2_kr_early", 32'(key_release), 0);
    cyc(1);
    check("t2_kr", 32'(key_release), 1);
    check("t2_kd_off", 32'(key_down), 0);
    cyc(1);
    check("t2_kr_1cyc", 32'(key_release), 0);

    // 3-cycle glitch rejected, 4-cycle glitch accepted both ways
    sw_raw[3] = 1'b1;
    cyc(3);
    sw_raw[3] = 1'b0;
    busy = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      if (sw_clean[3] | sw_change[3]) busy++;
    end
    check("t3_glitch3", 32'(busy), 0);
    sw_raw[3] = 1'b1;
    cyc(4);
    sw_raw[3] = 1'b0;
    cyc(1);
    check("t3_g4_early", 32'(sw_clean), 0);
    cyc(1);
    check("t3_g4_clean", 32'(sw_clean), 32'h8);
    check("t3_g4_change", 32'(sw_change), 32'h8);
    cyc(4);
    check("t3_g4_back", 32'(sw_clean), 0);
    check("t3_g4_change2", 32'(sw_change), 32'h8);

    // design select, then held through reset
    cyc(3);
    sw_raw[9] = 1'b1;
    cyc(5);
    check("t4_ds_early", 32'(design_sel), 0);
    cyc(1);
    check("t4_ds", 32'(design_sel), 1);
    check("t4_sw_change", 32'(sw_change), 32'h200);
    cyc(3);
    rst_n = 1'b0;
    #1;
    check("t4_ds_rst", 32'(design_sel), 0);
    check("t4_clean_rst", 32'(sw_clean), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    check("t4_ds_rel_early", 32'(design_sel), 0);
    cyc(1);
    check("t4_ds_rel", 32'(design_sel), 1);
    check("t4_change_rel", 32'(sw_change), 32'h200);

    // simultaneous edges on sw0, sw5 and key1
    cyc(3);
    sw_raw[0]  = 1'b1;
    sw_raw[5]  = 1'b1;
    key_raw[1] = 1'b0;
    cyc(5);
    check("t5_change_early", 32'(sw_change), 0);
    check("t5_press_early", 32'(key_press), 0);
    cyc(1);
    check("t5_change", 32'(sw_change), 32'h21);
    check("t5_press", 32'(key_press), 32'h2);
    check("t5_release", 32'(key_release), 0);
    check("t5_clean", 32'(sw_clean), 32'h221);

    // key 1 held: long press counted from the cycle key_down[1] rose
    npulse = 0;
    at = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (key_long != 2'b00) begin
        npulse++;
        if (at < 0) at = i;
      end
    end
`ifdef LONG_PRESS_EN
    check("t6_long_count", 32'(npulse), 1);
    check("t6_long_at", 32'(at), 20);
`else
    check("t6_long_count", 32'(npulse), 0);
`endif
    key_raw[1] = 1'b1;
    cyc(6);
    check("t6_release", 32'(key_release), 32'h2);
    check("t6_kd_off", 32'(key_down), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
